jk_count_sequencer: RTL and testbench
=====================================

JK_COUNT_SEQUENCER -- requirements
Module: jk_count_sequencer

Interface
REQ-001 Parameter WIDTH SHALL default to 4; it is the counter and JK-bank width in bits.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin counting, sampled in IDLE.
REQ-005 stop  input  1  abort counting, sampled in RUN and IDLE.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 oneshot  input  1  1 = halt at terminal count; 0 = wrap and continue.
REQ-008 load  input  1  synchronous parallel load of load_val.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 mod_n  input  WIDTH  upper bound of the count range 0..mod_n.
REQ-011 j_out  output  WIDTH  per-bit J excitation that drives the downstream JK flip-flop bank.
REQ-012 k_out  output  WIDTH  per-bit K excitation that drives the downstream JK flip-flop bank.
REQ-013 q  output  WIDTH  current count, registered.
REQ-014 qbar  output  WIDTH  bitwise complement of q at all times.
REQ-015 tc  output  1  terminal count, combinational.
REQ-016 busy  output  1  high while in RUN.
REQ-017 done  output  1  one-cycle pulse in DONE.

Function
REQ-018 q SHALL update on each rising clk edge using JK semantics per bit: q_next = (j_out & ~q) | (~k_out & q).
REQ-019 j_out and k_out SHALL be combinational functions of state, q, and inputs; q reflects them one cycle later (latency 1).
REQ-020 FSM states SHALL be IDLE, RUN, and DONE; the reset state is IDLE.
REQ-021 IDLE transitions: start=1 and stop=0 -> RUN; start=1 and stop=1 -> stay IDLE (stop wins).
REQ-022 RUN transitions: stop=1 -> IDLE with q held; tc=1 and oneshot=1 -> DONE with q held (no wrap).
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-024 Hold SHALL be encoded as j_out = k_out = 0, and hold applies in IDLE, DONE, on the RUN stop cycle, and on the oneshot terminal cycle.
REQ-025 Up count (RUN, up=1, tc=0): bit i SHALL toggle (J=K=1) iff all bits below i are 1; bit 0 always toggles; natural 2^WIDTH wrap applies.
REQ-026 Down count (RUN, up=0, tc=0): bit i SHALL toggle iff all bits below i are 0.
REQ-027 Wrap (RUN, oneshot=0, tc=1): when up=1, q -> 0 (J=0, K=1 per bit); when up=0, q -> mod_n (J=mod_n, K=~mod_n).
REQ-028 tc SHALL be 1 iff (up=1 and q==mod_n) or (up=0 and q==0), in any state.
REQ-029 load=1 SHALL force J=load_val and K=~load_val in any state, overriding counting, wrap, and hold; the FSM state is unaffected by load.
REQ-030 load SHALL take priority over the oneshot DONE transition; if load=1 and tc=1 with oneshot=1 in RUN, the state stays RUN.
REQ-031 If q > mod_n (reached via load) while counting up, counting SHALL continue with natural wrap; tc fires only on equality.
REQ-032 If mod_n=0 and up=1, tc SHALL be 1 at q=0; oneshot then goes RUN -> DONE on the first RUN cycle.
REQ-033 busy SHALL be 1 iff state==RUN, and done SHALL be 1 iff state==DONE.

Reset
REQ-034 While reset=1 (asynchronous): q=0, qbar=all ones, state=IDLE, busy=0, done=0; j_out=k_out=0 when load=0.
REQ-035 Reset asserted mid-RUN SHALL abort immediately with no further count; after release, the block idles until start.
REQ-036 The first rising clk edge after reset deassertion SHALL behave as a normal IDLE cycle.

Verification
REQ-037 Scenario: WIDTH=4, mod_n=5, up=1, oneshot=0, pulse start -> q = 1,2,3,4,5,0,1...; tc high when q=5; busy=1 throughout.
REQ-038 Scenario: mod_n=9, up=0, oneshot=1, load_val=3 with load then start -> q = 3,2,1,0; next cycle DONE with done=1 for one cycle and q=0 held; then IDLE.
REQ-039 Scenario: RUN at q=7 with up=1 and WIDTH=4 -> j_out=k_out=4'b1111, next q=8; at q=7 with stop=1 -> j_out=k_out=0, q stays 7, busy drops.
REQ-040 Scenario: start=stop=1 in IDLE -> stays IDLE; load=1 with load_val=4'hA in RUN at q=2 -> next q=A, state RUN.
REQ-041 Scenario: up=0, oneshot=0, mod_n=12, q=0 in RUN -> next q=12 (j_out=4'b1100, k_out=4'b0011).
REQ-042 Scenario: reset asserted between clock edges mid-RUN at q=6 -> q=0, qbar=4'hF, busy=0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/jk_count_sequencer.sv
// Up/down modulo counter sequenced by an IDLE/RUN/DONE FSM. The count is held in a
// bank of JK flip-flops, and the per-bit J/K excitations are exported for a downstream bank.
module jk_count_sequencer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             up,
   input  logic             oneshot,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_n,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] toggle;

   assign qbar = ~q;
   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);

   always_comb begin
      tc = up ? (q == mod_n) : (q == '0);
   end

   // A bit toggles when every lower bit is 1 (counting up) or 0 (counting down).
   always_comb begin
      toggle    = '0;
      toggle[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         toggle[i] = toggle[i-1] & ~(q[i-1] ^ up);
      end
   end

   always_comb begin
      state_d = state_q;
      j_out   = '0;
      k_out   = '0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop) state_d = StRun;
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
            end else if (tc && oneshot) begin
               if (!load) state_d = StDone;
            end else if (tc) begin
               j_out = up ? '0 : mod_n;
               k_out = up ? '1 : ~mod_n;
            end else begin
               j_out = toggle;
               k_out = toggle;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Load overrides every excitation but leaves the sequencing untouched.
      if (load) begin
         j_out = load_val;
         k_out = ~load_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         q       <= '0;
      end else begin
         state_q <= state_d;
         q       <= (j_out & ~q) | (~k_out & q);
      end
   end

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Self-checking bench for jk_count_sequencer: directed scenarios plus a randomized run
// compared cycle by cycle against an arithmetic reference model.
module tb_jk_count_sequencer;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, start, stop, up, oneshot, load;
   logic [W-1:0] load_val, mod_n;
   logic [W-1:0] j_out, k_out, q, qbar;
   logic         tc, busy, done;

   int checks = 0;
   int errors = 0;

   // Reference model: count value and mode (0 idle, 1 run, 2 done).
   logic [W-1:0] m_q;
   int           m_st;
   logic         e_tc;
   logic [W-1:0] e_j, e_k, e_nq;
   int           e_nst;

   jk_count_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .up(up), .oneshot(oneshot),
      .load(load), .load_val(load_val), .mod_n(mod_n), .j_out(j_out), .k_out(k_out),
      .q(q), .qbar(qbar), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic model_eval();
      e_tc  = up ? (m_q == mod_n) : (m_q == 4'd0);
      e_nq  = m_q;
      e_nst = m_st;
      e_j   = '0;
      e_k   = '0;
      case (m_st)
         0: if (start && !stop) e_nst = 1;
         1: begin
            if (stop) e_nst = 0;
            else if (e_tc && oneshot) e_nst = 2;
            else if (e_tc && up) begin
               e_nq = 4'd0;
               e_k  = '1;
            end else if (e_tc) begin
               e_nq = mod_n;
               e_j  = mod_n;
               e_k  = ~mod_n;
            end else begin
               e_nq = up ? m_q + 4'd1 : m_q - 4'd1;
               e_j  = m_q ^ e_nq;
               e_k  = e_j;
            end
         end
         default: e_nst = 0;
      endcase
      if (load) begin
         e_nq = load_val;
         e_j  = load_val;
         e_k  = ~load_val;
         if (e_nst == 2) e_nst = 1;
      end
   endtask

   task automatic drive(input logic s, input logic sp, input logic u, input logic os,
                        input logic ld, input logic [W-1:0] lv, input logic [W-1:0] mn);
      start = s; stop = sp; up = u; oneshot = os; load = ld; load_val = lv; mod_n = mn;
   endtask

   task automatic step();
      #1;
      model_eval();
      @(posedge clk);
      #1;
      m_q  = e_nq;
      m_st = e_nst;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 1, 0, 0, 4'h0, 4'd5);
      #2;
      checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", q); end
      checks++; if (qbar !== 4'hF) begin errors++; $display("FAIL reset_qbar: got %h expected f", qbar); end
      checks++; if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
      checks++; if ({j_out, k_out} !== 8'h00) begin
         errors++; $display("FAIL reset_jk: got %h expected 00", {j_out, k_out}); end
      @(posedge clk); #1;
      reset = 1'b0;
      m_q = '0; m_st = 0;
      step();
      checks++; if ({busy, q} !== 5'h00) begin
         errors++; $display("FAIL first_idle: got %h expected 00", {busy, q}); end
   endtask

   task automatic test_mod_count();
      int exp_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
      drive(1, 0, 1, 0, 0, 4'h0, 4'd5);
      step();
      drive(0, 0, 1, 0, 0, 4'h0, 4'd5);
      for (int i = 0; i < 7; i++) begin
         step();
         checks++; if (q !== 4'(exp_seq[i])) begin
            errors++; $display("FAIL mod_count_q[%0d]: got %h expected %h", i, q, exp_seq[i]); end
         checks++; if ({busy, tc} !== {1'b1, exp_seq[i] == 5}) begin
            errors++; $display("FAIL mod_count_busy_tc[%0d]: got %b", i, {busy, tc}); end
      end
      drive(0, 1, 1, 0, 0, 4'h0, 4'd5);
      step();
   endtask

   task automatic test_oneshot_down();
      drive(0, 0, 0, 1, 1, 4'd3, 4'd9);
      step();
      drive(1, 0, 0, 1, 0, 4'd0, 4'd9);
      step();
      checks++; if ({busy, q} !== 5'h13) begin
         errors++; $display("FAIL oneshot_start: got %h expected 13", {busy, q}); end
      drive(0, 0, 0, 1, 0, 4'd0, 4'd9);
      for (int i = 2; i >= 0; i--) begin
         step();
         checks++; if ({busy, q} !== {1'b1, 4'(i)}) begin
            errors++; $display("FAIL oneshot_q%0d: got %h expected %h", i, {busy, q}, {1'b1, 4'(i)}); end
      end
      #1;
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL oneshot_tc: got %b expected 1", tc); end
      step();
      checks++; if ({done, busy, q} !== 6'b10_0000) begin
         errors++; $display("FAIL oneshot_done: got %b expected 100000", {done, busy, q}); end
      step();
      checks++; if ({done, busy, q} !== 6'b00_0000) begin
         errors++; $display("FAIL oneshot_idle: got %b expected 000000", {done, busy, q}); end
   endtask

   task automatic test_stop();
      drive(0, 0, 1, 0, 1, 4'd7, 4'd15);
      step();
      drive(1, 0, 1, 0, 0, 4'd0, 4'd15);
      step();
      drive(0, 0, 1, 0, 0, 4'd0, 4'd15);
      #1;
      checks++; if ({j_out, k_out} !== 8'hFF) begin
         errors++; $display("FAIL q7_jk: got %h expected ff", {j_out, k_out}); end
      step();
      checks++; if (q !== 4'd8) begin errors++; $display("FAIL q7_next: got %h expected 8", q); end
      drive(0, 0, 1, 0, 1, 4'd7, 4'd15);
      step();
      drive(0, 1, 1, 0, 0, 4'd0, 4'd15);
      #1;
      checks++; if ({j_out, k_out} !== 8'h00) begin
         errors++; $display("FAIL stop_jk: got %h expected 00", {j_out, k_out}); end
      step();
      checks++; if ({busy, q} !== 5'h07) begin
         errors++; $display("FAIL stop_hold: got %h expected 07", {busy, q}); end
   endtask

   task automatic test_start_stop_load();
      drive(1, 1, 1, 0, 0, 4'd0, 4'd15);
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop: got %b expected 0", busy); end
      drive(1, 0, 1, 0, 1, 4'd2, 4'd15);
      step();
      drive(0, 0, 1, 0, 1, 4'hA, 4'd15);
      step();
      checks++; if ({busy, q} !== 5'h1A) begin
         errors++; $display("FAIL run_load: got %h expected 1a", {busy, q}); end
      drive(0, 1, 1, 0, 0, 4'd0, 4'd15);
      step();
   endtask

   task automatic test_down_wrap();
      drive(0, 0, 0, 0, 1, 4'd0, 4'd12);
      step();
      drive(1, 0, 0, 0, 0, 4'd0, 4'd12);
      step();
      drive(0, 0, 0, 0, 0, 4'd0, 4'd12);
      #1;
      checks++; if ({tc, j_out, k_out} !== 9'h1C3) begin
         errors++; $display("FAIL down_wrap_jk: got %h expected 1c3", {tc, j_out, k_out}); end
      step();
      checks++; if ({busy, q} !== 5'h1C) begin
         errors++; $display("FAIL down_wrap_q: got %h expected 1c", {busy, q}); end
      drive(0, 1, 0, 0, 0, 4'd0, 4'd12);
      step();
   endtask

   task automatic test_async_reset();
      drive(1, 0, 1, 0, 1, 4'd6, 4'd15);
      step();
      drive(0, 0, 1, 0, 0, 4'd0, 4'd15);
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({busy, q, qbar} !== 9'h00F) begin
         errors++; $display("FAIL async_reset: got %h expected 00f", {busy, q, qbar}); end
      @(posedge clk); #1;
      reset = 1'b0;
      m_q = '0; m_st = 0;
      step();
      checks++; if ({busy, q} !== 5'h00) begin
         errors++; $display("FAIL post_reset_idle: got %h expected 00", {busy, q}); end
   endtask

   task automatic test_random();
      logic [W-1:0] mn = 4'($urandom_range(0, 15));
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) mn = 4'($urandom_range(0, 15));
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, 1'($urandom),
               1'($urandom), $urandom_range(0, 13) == 0, 4'($urandom), mn);
         #1;
         model_eval();
         checks++; if ({q, qbar} !== {m_q, ~m_q}) begin
            errors++; $display("FAIL rand_q[%0d]: got %h expected %h", i, {q, qbar}, {m_q, ~m_q}); end
         checks++; if ({j_out, k_out} !== {e_j, e_k}) begin
            errors++; $display("FAIL rand_jk[%0d]: got %h expected %h", i, {j_out, k_out}, {e_j, e_k}); end
         checks++; if ({tc, busy, done} !== {e_tc, m_st == 1, m_st == 2}) begin
            errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", i, {tc, busy, done},
                               {e_tc, m_st == 1, m_st == 2}); end
         @(posedge clk); #1;
         m_q  = e_nq;
         m_st = e_nst;
      end
   endtask

   initial begin
      test_reset();
      test_mod_count();
      test_oneshot_down();
      test_stop();
      test_start_stop_load();
      test_down_wrap();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
